// File: rtl/cpc_io_master_if.sv
// cpc_io_master_if -- command/response handshake plus Z80/CPC bus strobes
// and address for cpc_io_master. The bidirectional data bus is a separate
// module port, so this interface carries only single-driver signals.
//
// Handshake semantics:
//   - A command transfers on a rising clock edge where i_CMD_VALID and
//     o_CMD_READY are both 1.
//   - o_CMD_READY is a registered output. The block does not look at valid
//     when it decides ready.
//   - i_CMD_OP/ADR/DATA/POLL_* are sampled only at that edge. They are
//     don't-care at every other time.
//   - o_RSP_VALID is a single-clock pulse with no back-pressure.
//   - o_RSP_TIMEOUT and o_RSP_ERROR are meaningful only while o_RSP_VALID=1.
//
// Modports:
//   master : the cpc_io_master side (commands in, bus and response out)
//   slave  : the host/command issuer side
interface cpc_io_master_if;
  logic        i_CMD_VALID;
  logic        o_CMD_READY;
  logic [1:0]  i_CMD_OP;
  logic [15:0] i_CMD_ADR;
  logic [7:0]  i_CMD_DATA;
  logic [7:0]  i_POLL_MASK;
  logic [7:0]  i_POLL_MATCH;
  logic        o_RSP_VALID;
  logic [7:0]  o_RSP_DATA;
  logic        o_RSP_TIMEOUT;
  logic        o_RSP_ERROR;
  logic        o_IORQ;
  logic        o_RD;
  logic        o_WR;
  logic [15:0] oADR;

  modport master (
    input  i_CMD_VALID, i_CMD_OP, i_CMD_ADR, i_CMD_DATA, i_POLL_MASK, i_POLL_MATCH,
    output o_CMD_READY, o_RSP_VALID, o_RSP_DATA, o_RSP_TIMEOUT, o_RSP_ERROR,
    output o_IORQ, o_RD, o_WR, oADR
  );

  modport slave (
    output i_CMD_VALID, i_CMD_OP, i_CMD_ADR, i_CMD_DATA, i_POLL_MASK, i_POLL_MATCH,
    input  o_CMD_READY, o_RSP_VALID, o_RSP_DATA, o_RSP_TIMEOUT, o_RSP_ERROR,
    input  o_IORQ, o_RD, o_WR, oADR
  );
endinterface

// File: rtl/cpc_io_master.sv
// cpc_io_master -- host-side Z80/CPC I/O cycle generator. It executes one
// command at a time and finishes each command with a one-clock response:
//   - write     : one bus write cycle
//   - read      : one bus read cycle
//   - poll-write: repeat status reads until (status & MASK) == (MATCH & MASK),
//                 then do one write. Gives up after POLL_LIMIT failed reads.
//   - op 11     : reserved. No bus activity, responds with the error flag.
//
// Each bus cycle runs T1, T2, TW, T3 and is followed by a GAP. Every one of
// these phases lasts T_STATE_CLKS clocks.
//
// Ports:
//   i_CLK, i_RESET : clock and synchronous active-high reset
//   bus            : command/response handshake, strobes and address
//                    (cpc_io_master_if.master)
//   ioCPC_DATA     : bidirectional data bus. The block drives it only during
//                    write cycles.
//   dbg_state      : current FSM state encoding
//   dbg_data_oe    : 1 while the block drives ioCPC_DATA
//
// Every output is a register loaded from next-state values, so there is no
// combinational path from any input to the bus pins.
module cpc_io_master #(
  parameter int T_STATE_CLKS = 4,
  parameter int POLL_LIMIT   = 255
) (
  input  logic                  i_CLK,
  input  logic                  i_RESET,
  cpc_io_master_if.master       bus,
  inout  wire  [7:0]            ioCPC_DATA,
  output logic [2:0]            dbg_state,
  output logic                  dbg_data_oe
);

  localparam int              CW     = (T_STATE_CLKS > 1) ? $clog2(T_STATE_CLKS) : 1;
  localparam logic [CW-1:0]   T_LAST = CW'(T_STATE_CLKS - 1);
  localparam logic [8:0]      LIMIT9 = 9'(POLL_LIMIT);

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_POLL  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE, ST_T1, ST_T2, ST_TW, ST_T3, ST_RSP, ST_GAP
  } state_t;

  state_t        state, nxt_state;
  logic [CW-1:0] tcnt, nxt_cnt;
  logic [1:0]    op_q;
  logic [15:0]   adr_q;
  logic [7:0]    data_q, mask_q, match_q, status_q, fail_cnt, nxt_fail;
  // cyc_write: the current or next bus cycle is a write.
  // gap_to_bus: GAP is followed by another bus cycle instead of IDLE.
  logic          cyc_write, nxt_cyc_write, gap_to_bus, nxt_gap_to_bus;
  logic          data_oe;

  logic accept, t_end, status_hit, limit_hit;
  logic rsp_set, rsp_to, rsp_err, rsp_from_bus, rsp_from_status, status_load;
  logic nxt_in_bus, nxt_strobe;

  assign accept     = (state == ST_IDLE) && bus.o_CMD_READY && bus.i_CMD_VALID;
  assign t_end      = (tcnt == T_LAST);
  assign status_hit = (((ioCPC_DATA ^ match_q) & mask_q) == 8'h00);
  assign limit_hit  = (POLL_LIMIT != 0) && (({1'b0, fail_cnt} + 9'd1) == LIMIT9);

  assign ioCPC_DATA  = data_oe ? data_q : 8'hzz;
  assign dbg_state   = state;
  assign dbg_data_oe = data_oe;

  always_comb begin
    nxt_state       = state;
    nxt_cnt         = tcnt;
    nxt_cyc_write   = cyc_write;
    nxt_gap_to_bus  = gap_to_bus;
    nxt_fail        = fail_cnt;
    rsp_set         = 1'b0;
    rsp_to          = 1'b0;
    rsp_err         = 1'b0;
    rsp_from_bus    = 1'b0;
    rsp_from_status = 1'b0;
    status_load     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          nxt_fail = 8'h00;
          nxt_cnt  = '0;
          if (bus.i_CMD_OP == 2'b11) begin
            nxt_state = ST_RSP;
            rsp_set   = 1'b1;
            rsp_err   = 1'b1;
          end else begin
            nxt_state     = ST_T1;
            nxt_cyc_write = (bus.i_CMD_OP == OP_WRITE);
          end
        end
      end
      ST_T1, ST_T2, ST_TW: begin
        if (t_end) begin
          nxt_cnt = '0;
          case (state)
            ST_T1:   nxt_state = ST_T2;
            ST_T2:   nxt_state = ST_TW;
            default: nxt_state = ST_T3;
          endcase
        end else begin
          nxt_cnt = tcnt + 1'b1;
        end
      end
      ST_T3: begin
        if (t_end) begin
          nxt_cnt        = '0;
          nxt_state      = ST_GAP;
          nxt_gap_to_bus = 1'b0;
          if (cyc_write) begin
            // The write ends the command. A poll-write reports the status
            // byte that satisfied the match.
            rsp_set         = 1'b1;
            rsp_from_status = (op_q == OP_POLL);
          end else begin
            // The bus data is sampled on the last clock of T3.
            status_load = 1'b1;
            if (op_q == OP_READ) begin
              rsp_set      = 1'b1;
              rsp_from_bus = 1'b1;
            end else if (status_hit) begin
              nxt_gap_to_bus = 1'b1;
              nxt_cyc_write  = 1'b1;
            end else begin
              nxt_fail = fail_cnt + 8'd1;
              if (limit_hit) begin
                rsp_set      = 1'b1;
                rsp_to       = 1'b1;
                rsp_from_bus = 1'b1;
              end else begin
                nxt_gap_to_bus = 1'b1;
              end
            end
          end
        end else begin
          nxt_cnt = tcnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (t_end) begin
          nxt_cnt   = '0;
          nxt_state = gap_to_bus ? ST_T1 : ST_IDLE;
        end else begin
          nxt_cnt = tcnt + 1'b1;
        end
      end
      ST_RSP: begin
        nxt_state = ST_IDLE;
      end
      default: begin
        nxt_state = ST_IDLE;
      end
    endcase

    nxt_in_bus = (nxt_state == ST_T1) || (nxt_state == ST_T2) ||
                 (nxt_state == ST_TW) || (nxt_state == ST_T3);
    nxt_strobe = (nxt_state == ST_T2) || (nxt_state == ST_TW) || (nxt_state == ST_T3);
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state             <= ST_IDLE;
      tcnt              <= '0;
      op_q              <= 2'b00;
      adr_q             <= 16'h0000;
      data_q            <= 8'h00;
      mask_q            <= 8'h00;
      match_q           <= 8'h00;
      status_q          <= 8'h00;
      fail_cnt          <= 8'h00;
      cyc_write         <= 1'b0;
      gap_to_bus        <= 1'b0;
      data_oe           <= 1'b0;
      bus.o_IORQ        <= 1'b1;
      bus.o_RD          <= 1'b1;
      bus.o_WR          <= 1'b1;
      bus.oADR          <= 16'h0000;
      bus.o_CMD_READY   <= 1'b0;
      bus.o_RSP_VALID   <= 1'b0;
      bus.o_RSP_DATA    <= 8'h00;
      bus.o_RSP_TIMEOUT <= 1'b0;
      bus.o_RSP_ERROR   <= 1'b0;
    end else begin
      state      <= nxt_state;
      tcnt       <= nxt_cnt;
      fail_cnt   <= nxt_fail;
      cyc_write  <= nxt_cyc_write;
      gap_to_bus <= nxt_gap_to_bus;
      if (accept) begin
        op_q    <= bus.i_CMD_OP;
        adr_q   <= bus.i_CMD_ADR;
        data_q  <= bus.i_CMD_DATA;
        mask_q  <= bus.i_POLL_MASK;
        match_q <= bus.i_POLL_MATCH;
      end
      if (status_load) status_q <= ioCPC_DATA;

      // Both strobes are decoded from the same cycle-type bit, so RD and WR
      // can never be low in the same clock.
      bus.o_IORQ <= !nxt_strobe;
      bus.o_RD   <= !(nxt_strobe && !nxt_cyc_write);
      bus.o_WR   <= !(nxt_strobe && nxt_cyc_write);
      // At the accept edge the address register is still being loaded, so
      // the address comes straight from the command input.
      bus.oADR   <= nxt_in_bus ? (accept ? bus.i_CMD_ADR : adr_q) : 16'h0000;
      data_oe    <= nxt_in_bus && nxt_cyc_write;

      bus.o_CMD_READY   <= (nxt_state == ST_IDLE);
      bus.o_RSP_VALID   <= rsp_set;
      bus.o_RSP_TIMEOUT <= rsp_to;
      bus.o_RSP_ERROR   <= rsp_err;
      if (rsp_from_bus)         bus.o_RSP_DATA <= ioCPC_DATA;
      else if (rsp_from_status) bus.o_RSP_DATA <= status_q;
    end
  end

endmodule

// File: tb/tb_cpc_io_master.sv
// Bench for cpc_io_master with T_STATE_CLKS=2 and POLL_LIMIT=3.
// Clock numbering: the accept edge ends clock 0. Outputs are sampled on the
// falling edge of every later clock.
module tb_cpc_io_master;
  localparam int N = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpc_io_master_if bus ();
  wire  [7:0] cpc_data;
  logic [7:0] tb_status;
  logic [2:0] dbg_state;
  logic       dbg_oe;

  // Status device: drives the data bus only while RD is low.
  assign cpc_data = (!bus.o_RD) ? tb_status : 8'hzz;

  cpc_io_master #(.T_STATE_CLKS(N), .POLL_LIMIT(3)) dut (
    .i_CLK       (clk),
    .i_RESET     (rst),
    .bus         (bus),
    .ioCPC_DATA  (cpc_data),
    .dbg_state   (dbg_state),
    .dbg_data_oe (dbg_oe)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] adr;
    logic [7:0]  data, mask, match, st0, st1, st2;
    int          rsp_clk, rdy_clk;
    logic [7:0]  rsp_data;
    logic        to, err;
    int          rd_clks, wr_clks, first_iorq, first_oe, oe_clks;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] op, input logic [15:0] adr,
                              input logic [7:0] data, mask, match, st0, st1, st2,
                              input int rsp_clk, rdy_clk, input logic [7:0] rsp_data,
                              input logic to, err, input int rd_clks, wr_clks,
                              first_iorq, first_oe, oe_clks);
    vec_t v;
    v.op = op; v.adr = adr; v.data = data; v.mask = mask; v.match = match;
    v.st0 = st0; v.st1 = st1; v.st2 = st2;
    v.rsp_clk = rsp_clk; v.rdy_clk = rdy_clk; v.rsp_data = rsp_data;
    v.to = to; v.err = err; v.rd_clks = rd_clks; v.wr_clks = wr_clks;
    v.first_iorq = first_iorq; v.first_oe = first_oe; v.oe_clks = oe_clks;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  // Presents a command and returns at the falling edge of clock 1.
  task automatic issue(input logic [1:0] op, input logic [15:0] adr,
                       input logic [7:0] data, mask, match);
    int waited = 0;
    @(negedge clk);
    bus.i_CMD_OP = op; bus.i_CMD_ADR = adr; bus.i_CMD_DATA = data;
    bus.i_POLL_MASK = mask; bus.i_POLL_MATCH = match;
    bus.i_CMD_VALID = 1'b1;
    while (!bus.o_CMD_READY && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.o_CMD_READY) check("issue_ready_wait", 0, 1);
    @(posedge clk);
    @(negedge clk);
    bus.i_CMD_VALID = 1'b0;
    // Fields are captured at acceptance, so later garbage must not matter.
    bus.i_CMD_OP    = 2'($urandom_range(0, 3));
    bus.i_CMD_ADR   = 16'($urandom);
    bus.i_CMD_DATA  = 8'($urandom);
    bus.i_POLL_MASK = 8'($urandom);
    bus.i_POLL_MATCH = 8'($urandom);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int c = 1, rsp_clk = 0, rdy_clk = 0, rsp_cnt = 0;
    int rd_clks = 0, wr_clks = 0, first_iorq = 0, first_oe = 0, oe_clks = 0;
    int bad_adr = 0, bad_dat = 0, bad_bus = 0, rd_idx = 0;
    logic [7:0] got_data = 8'h00;
    logic got_to = 1'b0, got_err = 1'b0, rd_prev = 1'b1, done = 1'b0;
    logic [7:0] exp_data;
    string p;
    p = $sformatf("v%0d_", idx);
    tb_status = v.st0;
    exp_q.push_back(v.rsp_data);
    issue(v.op, v.adr, v.data, v.mask, v.match);
    while (!done && c <= 200) begin
      if (c > 1) @(negedge clk);
      if (rd_prev == 1'b0 && bus.o_RD == 1'b1) begin
        rd_idx++;
        tb_status = (rd_idx == 1) ? v.st1 : v.st2;
      end
      rd_prev = bus.o_RD;
      if (!bus.o_RD) rd_clks++;
      if (!bus.o_WR) wr_clks++;
      if (!bus.o_IORQ) begin
        if (first_iorq == 0) first_iorq = c;
        if (bus.oADR != v.adr) bad_adr++;
      end
      if (dbg_oe) begin
        oe_clks++;
        if (first_oe == 0) first_oe = c;
        if (cpc_data != v.data) bad_dat++;
      end
      if ((!bus.o_RD && !bus.o_WR) || (dbg_oe && !bus.o_RD) ||
          ((!bus.o_RD || !bus.o_WR) && bus.o_IORQ)) bad_bus++;
      if (bus.o_RSP_VALID) begin
        rsp_cnt++;
        if (rsp_clk == 0) begin
          rsp_clk = c; got_data = bus.o_RSP_DATA;
          got_to = bus.o_RSP_TIMEOUT; got_err = bus.o_RSP_ERROR;
        end
      end else if (bus.o_RSP_TIMEOUT || bus.o_RSP_ERROR) begin
        bad_bus++;
      end
      if (rsp_clk == 0 && bus.o_CMD_READY) bad_bus++;
      if (rsp_clk != 0 && c > rsp_clk && bus.o_CMD_READY) begin
        rdy_clk = c;
        done = 1'b1;
      end
      c++;
    end
    check({p, "finished"}, 32'(done), 1);
    exp_data = exp_q.pop_front();
    check({p, "rsp_clk"}, rsp_clk, v.rsp_clk);
    check({p, "ready_clk"}, rdy_clk, v.rdy_clk);
    check({p, "rsp_data"}, 32'(got_data), 32'(exp_data));
    check({p, "rsp_timeout"}, 32'(got_to), 32'(v.to));
    check({p, "rsp_error"}, 32'(got_err), 32'(v.err));
    check({p, "rsp_pulses"}, rsp_cnt, 1);
    check({p, "rd_clks"}, rd_clks, v.rd_clks);
    check({p, "wr_clks"}, wr_clks, v.wr_clks);
    check({p, "first_iorq"}, first_iorq, v.first_iorq);
    check({p, "first_data_drive"}, first_oe, v.first_oe);
    check({p, "data_drive_clks"}, oe_clks, v.oe_clks);
    check({p, "adr_errs"}, bad_adr, 0);
    check({p, "data_errs"}, bad_dat, 0);
    check({p, "bus_rule_errs"}, bad_bus, 0);
  endtask

  // ---------------- stimulus ----------------
  vec_t vecs[10];
  vec_t v_after_rst, v_final;

  initial begin
    int bad;
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int bad;
    //              op     adr      data   mask   match  st0    st1    st2   rsp rdy data   to err rd  wr fi fo oe
    vecs[0] = mk(2'b00, 16'hFBEE, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,  9, 11, 8'h00, 0, 0,  0, 6, 3, 1, 8);
    vecs[1] = mk(2'b01, 16'hFBFE, 8'h00, 8'h00, 8'h00, 8'hC3, 8'hC3, 8'hC3,  9, 11, 8'hC3, 0, 0,  6, 0, 3, 0, 0);
    vecs[2] = mk(2'b00, 16'hFAEE, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,  9, 11, 8'hC3, 0, 0,  0, 6, 3, 1, 8);
    vecs[3] = mk(2'b11, 16'h1234, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,  1,  2, 8'hC3, 0, 1,  0, 0, 0, 0, 0);
    vecs[4] = mk(2'b01, 16'hFF12, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h3C, 8'h3C,  9, 11, 8'h3C, 0, 0,  6, 0, 3, 0, 0);
    vecs[5] = mk(2'b10, 16'hFBEE, 8'h21, 8'h40, 8'h40, 8'h00, 8'h00, 8'h40, 39, 41, 8'h40, 0, 0, 18, 6, 3, 31, 8);
    vecs[6] = mk(2'b10, 16'hFBEE, 8'h22, 8'h40, 8'h40, 8'h00, 8'h00, 8'h00, 29, 31, 8'h00, 1, 0, 18, 0, 3, 0, 0);
    vecs[7] = mk(2'b10, 16'hFAEE, 8'h07, 8'h0F, 8'hF5, 8'h35, 8'h35, 8'h35, 19, 21, 8'h35, 0, 0,  6, 6, 3, 11, 8);
    vecs[8] = mk(2'b10, 16'hFBEE, 8'h3E, 8'h80, 8'h80, 8'h7F, 8'hFF, 8'hFF, 29, 31, 8'hFF, 0, 0, 12, 6, 3, 21, 8);
    vecs[9] = mk(2'b11, 16'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,  1,  2, 8'hFF, 0, 1,  0, 0, 0, 0, 0);
    v_after_rst = mk(2'b01, 16'hFBFE, 8'h00, 8'h00, 8'h00, 8'h96, 8'h96, 8'h96, 9, 11, 8'h96, 0, 0, 6, 0, 3, 0, 0);
    v_final     = mk(2'b00, 16'hFBEE, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 9, 11, 8'h00, 0, 0, 0, 6, 3, 1, 8);

    tb_status = 8'h00;
    bus.i_CMD_VALID = 1'b0; bus.i_CMD_OP = 2'b00; bus.i_CMD_ADR = 16'h0000;
    bus.i_CMD_DATA = 8'h00; bus.i_POLL_MASK = 8'h00; bus.i_POLL_MATCH = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_iorq", 32'(bus.o_IORQ), 1);
    check("rst_rd", 32'(bus.o_RD), 1);
    check("rst_wr", 32'(bus.o_WR), 1);
    check("rst_adr", 32'(bus.oADR), 0);
    check("rst_data_drive", 32'(dbg_oe), 0);
    check("rst_rsp_valid", 32'(bus.o_RSP_VALID), 0);
    check("rst_rsp_data", 32'(bus.o_RSP_DATA), 0);
    check("rst_rsp_timeout", 32'(bus.o_RSP_TIMEOUT), 0);
    check("rst_rsp_error", 32'(bus.o_RSP_ERROR), 0);
    check("rst_ready", 32'(bus.o_CMD_READY), 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_release", 32'(bus.o_CMD_READY), 1);

    // Table-driven commands
    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Reset asserted during TW of a write
    issue(2'b00, 16'hFBEE, 8'h11, 8'h00, 8'h00);
    repeat (4) @(negedge clk);            // clock 5, first TW clock
    check("rA_tw_wr_low", 32'(bus.o_WR), 0);
    check("rA_tw_data", 32'(cpc_data), 32'h11);
    rst = 1'b1;
    @(negedge clk);                        // clock 6, after the reset edge
    check("rA_iorq", 32'(bus.o_IORQ), 1);
    check("rA_wr", 32'(bus.o_WR), 1);
    check("rA_rd", 32'(bus.o_RD), 1);
    check("rA_data_drive", 32'(dbg_oe), 0);
    check("rA_rsp_valid", 32'(bus.o_RSP_VALID), 0);
    check("rA_ready", 32'(bus.o_CMD_READY), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rA_ready_after_release", 32'(bus.o_CMD_READY), 1);
    bad = 0;
    repeat (11) begin
      @(negedge clk);
      if (bus.o_RSP_VALID || !bus.o_IORQ || dbg_oe) bad++;
    end
    check("rA_no_activity", bad, 0);
    run_vec(v_after_rst, 10);

    // A command held valid across reset release must be ignored
    @(negedge clk);
    rst = 1'b1;
    bus.i_CMD_OP = 2'b00; bus.i_CMD_ADR = 16'hFBEE; bus.i_CMD_DATA = 8'h99;
    bus.i_CMD_VALID = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rB_ready_after_release", 32'(bus.o_CMD_READY), 1);
    bus.i_CMD_VALID = 1'b0;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (!bus.o_IORQ || dbg_oe || dbg_state != 3'd0 || bus.o_RSP_VALID) bad++;
    end
    check("rB_cmd_ignored", bad, 0);
    run_vec(v_final, 11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpc_io_master.md
# cpc_io_master

Host-side Z80/CPC I/O cycle generator that drives the expansion-bus strobes (IORQ, RD, WR), address and data lines toward the speech/serial interface CPLD. It is the initiator for the CPLD's I/O-port responder. It serves as the host model for board bring-up and as the on-board master for self-test. It accepts single commands (write, read, or poll-then-write) and returns a one-cycle response with read data and status flags. Poll-then-write implements the SSA-1/DKtronics "wait for LRQ, then send allophone" loop in hardware.

## Interface
Parameters:
- T_STATE_CLKS, 4, i_CLK cycles per Z80 T-state (≥1)
- POLL_LIMIT, 255, non-matching status reads before timeout (8-bit; 0 = poll forever)

Ports:
- i_CLK  in  1  single system clock; all logic on rising edge
- i_RESET  in  1  reset, synchronous, active-high
- i_CMD_VALID  in  1  command request
- o_CMD_READY  out  1  block can accept a command; a command is accepted when valid & ready
- i_CMD_OP  in  2  00 write, 01 read, 10 poll-write, 11 reserved
- i_CMD_ADR  in  16  I/O port address (e.g. FBEE, FAEE, FBFE, FFxx)
- i_CMD_DATA  in  8  write byte
- i_POLL_MASK  in  8  status bits compared in poll-write
- i_POLL_MATCH  in  8  required value of masked status bits
- o_RSP_VALID  out  1  one-cycle response pulse
- o_RSP_DATA  out  8  read byte / last status read; held until the next response
- o_RSP_TIMEOUT  out  1  poll-write gave up; qualified by o_RSP_VALID
- o_RSP_ERROR  out  1  reserved op; qualified by o_RSP_VALID
- o_IORQ, o_RD, o_WR  out  1 each  active-low bus strobes
- oADR  out  16  bus address
- ioCPC_DATA  inout  8  bus data; driven only during write cycles, else Z

## Operation
- Command fields are captured at acceptance. Inputs are ignored while busy.
- FSM states: IDLE, T1, T2, TW, T3, RSP, GAP. Each of T1/T2/TW/T3/GAP lasts exactly T_STATE_CLKS clocks; RSP lasts 1 clock and overlaps the first GAP clock (RSP is an output pulse, not extra time).
- Bus cycle, common to read and write:
  - oADR = captured address from the first T1 clock through the last T3 clock.
  - o_IORQ low for all of T2, TW and T3.
- Read: o_RD low with o_IORQ. ioCPC_DATA is sampled on the last clock of T3 into o_RSP_DATA.
- Write: ioCPC_DATA is driven with the data byte from the first T1 clock through the last T3 clock. o_WR low with o_IORQ.
- Poll-write sequence:
  - Read cycle, then GAP.
  - If (status & MASK) == (MATCH & MASK): write cycle, RSP with o_RSP_DATA = matching status, GAP, IDLE.
  - Otherwise increment the fail counter. At POLL_LIMIT (≠0), RSP with o_RSP_TIMEOUT=1 and no write. Else start a new read.
  - The fail counter clears on every accepted command.
- Reserved op 11: no bus activity. RSP with o_RSP_ERROR=1 in the clock after acceptance, then IDLE (no GAP).
- o_RSP_TIMEOUT and o_RSP_ERROR are 0 when o_RSP_VALID=0.
- o_CMD_READY is 1 only in IDLE.

## Timing
- Reset values, registered, effective the clock after i_RESET samples high:
  - o_IORQ=o_RD=o_WR=1
  - oADR=0000, ioCPC_DATA=Z
  - o_RSP_VALID=0, o_RSP_DATA=00, o_RSP_TIMEOUT=0, o_RSP_ERROR=0
  - o_CMD_READY=0 while i_RESET=1; o_CMD_READY=1 from the first clock after release
- Reset mid-operation: strobes deassert and the bus releases on the next edge. The pending command is dropped with no response.
- All outputs are registered; there are no combinational paths from inputs to bus pins.
- Write/read latency, acceptance at clock 0, N=T_STATE_CLKS:
  - T1 = clocks 1..N, T2 = N+1..2N, TW = 2N+1..3N, T3 = 3N+1..4N
  - RSP pulse at clock 4N+1; GAP = 4N+1..5N
  - o_CMD_READY=1 at clock 5N+1
- Poll-write, k failed reads then a match: response at (k+1)·5N + 4N + 1.
- Strobes never overlap: o_RD and o_WR are never low in the same clock.
- Data is driven one T-state before o_WR falls and held until o_WR rises (setup/hold to the CPLD's posedge latch).
- Back-to-back commands are always separated by at least one GAP T-state with all strobes high.
- If valid & ready coincides with reset release, the command is ignored.

## Test plan
- N=2, write FBEE/0x5A: o_IORQ and o_WR low on clocks 3..8, data 0x5A on clocks 1..8, RSP at clock 9 with RSP_DATA unchanged, ready at clock 11.
- N=2, read FBFE with the bench driving 0xC3 in T3: o_RD low on clocks 3..8, RSP at clock 9 with RSP_DATA=C3, ioCPC_DATA never driven by the DUT.
- Poll-write FBEE, MASK=40, MATCH=40; status 00 for two reads then 40: three read cycles, one write, RSP_DATA=40, TIMEOUT=0.
- POLL_LIMIT=3, status stuck at 00: exactly 3 reads, no write cycle, RSP with TIMEOUT=1, RSP_DATA=00.
- Op 11: RSP with ERROR=1 in the next clock, no strobe activity, ready again the following clock.
- i_RESET asserted during TW of a write: the next clock has strobes high, bus Z, no RSP; a command issued after release completes normally.
